// File: rtl/inter_pkg.sv
// Shared types and sizes for the interconnect slave endpoint.
package inter_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 8;
    localparam int BUSY_W = 3;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_READY = 2'd1,
        S_BUSY  = 2'd2
    } state_t;
endpackage

// File: rtl/slave_wait_ctr.sv
// Loadable down-counter that times the busy phase after an accepted write.
module slave_wait_ctr
    import inter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BUSY_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);
    logic [BUSY_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - BUSY_W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/inter_slave.sv
// Slave endpoint: accepts writes into an 8x3 register file, then stalls
// ready_out for BUSY_CYCLES cycles before accepting again.
//
//   state   | meaning
//   S_INIT  | one-cycle settle after reset, ready_out low
//   S_READY | ready_out high, a write is accepted when valid_in is high
//   S_BUSY  | ready_out low until the wait counter reaches zero
module inter_slave
    import inter_pkg::*;
#(
    parameter int BUSY_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] value_in,
    output logic              ready_out,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  wr_count,
    output logic              done_pulse,
    output logic              overwrite_pulse
);
    localparam bit HAS_BUSY = (BUSY_CYCLES > 0);
    localparam logic [BUSY_W-1:0] BUSY_LOAD =
        HAS_BUSY ? BUSY_W'(BUSY_CYCLES - 1) : '0;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  vbit;
    logic              accept;
    logic              ctr_zero;

    // ready_out is registered and mirrors S_READY, so accept never loops back
    // combinationally through valid_in.
    assign accept = valid_in & ready_out;

    slave_wait_ctr u_wait_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (BUSY_LOAD),
        .dec      (state == S_BUSY),
        .zero     (ctr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            ready_out <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    state     <= S_READY;
                    ready_out <= 1'b1;
                end
                S_READY: begin
                    if (accept && HAS_BUSY) begin
                        state     <= S_BUSY;
                        ready_out <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (ctr_zero) begin
                        state     <= S_READY;
                        ready_out <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_INIT;
                    ready_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            vbit            <= '0;
            wr_count        <= '0;
            done_pulse      <= 1'b0;
            overwrite_pulse <= 1'b0;
        end else begin
            done_pulse      <= accept;
            overwrite_pulse <= accept & vbit[addr_in];
            if (accept) begin
                mem[addr_in]  <= value_in;
                vbit[addr_in] <= 1'b1;
                if (wr_count != {CNT_W{1'b1}}) begin
                    wr_count <= wr_count + CNT_W'(1);
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: tb/tb_inter_slave.sv
// Checks two slave endpoints (BUSY_CYCLES=2 and 0) against a cycle-count
// reference model of the accept/busy rules and register-file contents.
module tb_inter_slave;
    logic            clk;
    logic            rst_n;
    logic [1:0]      v;
    logic [1:0][2:0] a;
    logic [1:0][2:0] d;
    logic [1:0][2:0] rd_addr;
    logic [1:0][2:0] rdd;
    logic [1:0]      rdy;
    logic [1:0]      done;
    logic [1:0]      ovw;
    logic [1:0][7:0] wc;

    int checks = 0;
    int errors = 0;

    // Reference model: a slave is ready once the edge count reaches ready_from.
    int       cyc;
    int       ready_from [2];
    logic [2:0] mmem [2][8];
    bit       mv [2][8];
    int       mcnt [2];
    bit       exp_done [2];
    bit       exp_ovw [2];
    bit       last_acc [2];

    inter_slave #(.BUSY_CYCLES(2), .CNT_W(8)) dut_b2 (
        .clk(clk), .rst_n(rst_n), .valid_in(v[0]), .addr_in(a[0]), .value_in(d[0]),
        .ready_out(rdy[0]), .rd_addr(rd_addr[0]), .rd_data(rdd[0]), .wr_count(wc[0]),
        .done_pulse(done[0]), .overwrite_pulse(ovw[0])
    );

    inter_slave #(.BUSY_CYCLES(0), .CNT_W(8)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .valid_in(v[1]), .addr_in(a[1]), .value_in(d[1]),
        .ready_out(rdy[1]), .rd_addr(rd_addr[1]), .rd_data(rdd[1]), .wr_count(wc[1]),
        .done_pulse(done[1]), .overwrite_pulse(ovw[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int busy_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_clear();
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            ready_from[k] = 1;
            mcnt[k] = 0;
            exp_done[k] = 0;
            exp_ovw[k] = 0;
            last_acc[k] = 0;
            for (int i = 0; i < 8; i++) begin
                mmem[k][i] = '0;
                mv[k][i] = 0;
            end
        end
    endtask

    task automatic step();
        bit pre_rdy;
        bit acc;
        for (int k = 0; k < 2; k++) rd_addr[k] = a[k];
        #1;
        for (int k = 0; k < 2; k++) chk("rd_before_edge", k, 32'(rdd[k]), 32'(mmem[k][a[k]]));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            pre_rdy = (cyc >= ready_from[k]);
            acc = v[k] && pre_rdy;
            last_acc[k] = acc;
            exp_done[k] = acc;
            exp_ovw[k] = acc && mv[k][a[k]];
            if (acc) begin
                mmem[k][a[k]] = d[k];
                mv[k][a[k]] = 1;
                if (mcnt[k] < 255) mcnt[k]++;
                ready_from[k] = cyc + 1 + busy_of(k);
            end
        end
        cyc++;
        #1;
        for (int k = 0; k < 2; k++) rd_addr[k] = 3'($urandom_range(0, 7));
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("ready_out", k, 32'(rdy[k]), 32'(cyc >= ready_from[k]));
            chk("done_pulse", k, 32'(done[k]), 32'(exp_done[k]));
            chk("overwrite_pulse", k, 32'(ovw[k]), 32'(exp_ovw[k]));
            chk("wr_count", k, 32'(wc[k]), 32'(mcnt[k]));
            chk("rd_data", k, 32'(rdd[k]), 32'(mmem[k][rd_addr[k]]));
        end
    endtask

    task automatic do_reset();
        v = '0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", k, 32'(rdy[k]), 0);
            chk("rst_done", k, 32'(done[k]), 0);
            chk("rst_ovw", k, 32'(ovw[k]), 0);
            chk("rst_count", k, 32'(wc[k]), 0);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr[0] = 3'(i);
            rd_addr[1] = 3'(i);
            #1;
            for (int k = 0; k < 2; k++) chk("rst_mem", k, 32'(rdd[k]), 0);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) chk("init_ready_low", k, 32'(rdy[k]), 0);
    endtask

    task automatic write(input int k, input logic [2:0] aa, input logic [2:0] dd);
        int n;
        n = 0;
        v[k] = 1'b1;
        a[k] = aa;
        d[k] = dd;
        do begin
            step();
            n++;
        end while (!last_acc[k] && n < 20);
        chk("write_done", k, 32'(done[k]), 1);
        v[k] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        v = '0;
        a = '0;
        d = '0;
        rd_addr = '0;
        model_clear();
        #12;
        do_reset();
        repeat (3) step();

        write(0, 3'd5, 3'd6);
        chk("first_count", 0, 32'(wc[0]), 1);
        chk("first_ovw", 0, 32'(ovw[0]), 0);
        repeat (3) step();
        rd_addr[0] = 3'd5;
        #1;
        chk("rd_addr5", 0, 32'(rdd[0]), 6);

        write(0, 3'd5, 3'd3);
        chk("second_ovw", 0, 32'(ovw[0]), 1);
        chk("second_count", 0, 32'(wc[0]), 2);
        // Issued straight into the busy window: must wait for ready_out.
        write(0, 3'd1, 3'd7);
        chk("held_count", 0, 32'(wc[0]), 3);
        repeat (3) step();
        rd_addr[0] = 3'd1;
        #1;
        chk("rd_addr1", 0, 32'(rdd[0]), 7);

        for (int i = 0; i < 4; i++) begin
            v[1] = 1'b1;
            a[1] = 3'(i);
            d[1] = 3'($urandom_range(0, 7));
            step();
            chk("b2b_ready", 1, 32'(rdy[1]), 1);
            chk("b2b_done", 1, 32'(done[1]), 1);
        end
        v[1] = 1'b0;
        chk("b2b_count", 1, 32'(wc[1]), 4);
        step();

        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < 2; k++) begin
                v[k] = 1'($urandom_range(0, 1));
                a[k] = 3'($urandom_range(0, 7));
                d[k] = 3'($urandom_range(0, 7));
            end
            step();
        end
        v = '0;

        write(0, 3'd2, 3'd4);
        step();
        #2;
        do_reset();
        repeat (3) step();

        v[1] = 1'b1;
        for (int n = 0; n < 300; n++) begin
            a[1] = 3'($urandom_range(0, 7));
            d[1] = 3'($urandom_range(0, 7));
            step();
        end
        v[1] = 1'b0;
        step();
        chk("sat_count", 1, 32'(wc[1]), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inter_slave.md
Name: inter_slave

Overview:
- Downstream slave endpoint for the two-master interconnect.
- Consumes one slave channel (valid, 3-bit address, 3-bit value) and answers with a registered ready.
- Stores accepted values in an 8-entry x 3-bit register file, then goes busy for a programmable number of cycles before accepting again.
- Two instances hang off the interconnect, one per slave port; the interconnect's ready_slaveN inputs are driven by ready_out.

Parameters:
- BUSY_CYCLES, 2, number of cycles ready_out stays low after each accepted write (legal 0..7).
- CNT_W, 8, width of the saturating accepted-write counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  write request from interconnect (valid_slaveN).
- addr_in  input  3  write address (addr_out of interconnect).
- value_in  input  3  write data (value_out of interconnect).
- ready_out  output  1  slave can accept this cycle; registered.
- rd_addr  input  3  debug/readback address.
- rd_data  output  3  combinational read of mem[rd_addr].
- wr_count  output  CNT_W  number of accepted writes, saturating.
- done_pulse  output  1  one-cycle pulse the cycle after an accepted write.
- overwrite_pulse  output  1  with done_pulse when the written entry already held data since reset.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state S_INIT; ready_out 0; mem all 0; entry-valid bits 0; wr_count 0; done_pulse 0; overwrite_pulse 0.
- Handshake: an accept occurs on a rising edge where valid_in=1 and ready_out=1. valid_in while ready_out=0 is ignored; no capture, no side effects. The master holds the request.
- States:
  - S_INIT: ready_out=0 for exactly one cycle after reset release, then S_READY.
  - S_READY: ready_out=1. On accept: mem[addr_in]<=value_in and vbit[addr_in]<=1. Next state is S_BUSY if BUSY_CYCLES>0, else stay in S_READY (back-to-back accepts allowed).
  - S_BUSY: ready_out=0. A down-counter loads BUSY_CYCLES-1 on entry and decrements each cycle. At 0 → S_READY. ready_out is therefore low for exactly BUSY_CYCLES cycles after the accept edge.
- ready_out is a decode of the registered state only; it never depends combinationally on valid_in.
- done_pulse: registered, high for the one cycle following each accept.
- overwrite_pulse: registered, equal to the pre-accept vbit[addr_in], asserted only alongside done_pulse.
- wr_count: increments on accept and saturates at 2^CNT_W-1, with no wrap.
- rd_data: combinational from mem. If rd_addr equals the address written on the same edge, rd_data shows the old value until after that edge.
- Illegal state encoding → S_INIT.
- Reset mid-busy: all state cleared immediately (asynchronous); the sequence restarts from S_INIT.
- addr_in/value_in are don't-care when valid_in=0 or ready_out=0.

Decomposition:
- Package inter_pkg:
  - state enum {S_INIT, S_READY, S_BUSY} on 2 bits;
  - ADDR_W=3, DATA_W=3, DEPTH=8;
  - a localparam helper for the busy-counter width (3 bits).
- One sub-module, slave_wait_ctr: loadable 3-bit down-counter with load, dec and zero flag, instantiated for the busy phase.
- The register file and counter stay in the top level.

Test Plan:
- Reset release, valid_in=0 → ready_out 0 in the first cycle, 1 from the second; all outputs 0; rd_data=0 for every rd_addr.
- BUSY_CYCLES=2: accept addr=5, value=6 → done_pulse 1 for one cycle; ready_out low for exactly 2 cycles then high; rd_addr=5 gives 6; wr_count=1; overwrite_pulse 0.
- Second write to addr=5 value=3 after busy → overwrite_pulse 1 with done_pulse; rd_data=3; wr_count=2.
- valid_in held high during busy with addr=1 value=7 → no capture until ready_out returns. Then exactly one accept; mem[1]=7; wr_count increments once.
- BUSY_CYCLES=0: valid_in high for 4 consecutive cycles on addrs 0..3 → 4 accepts back-to-back; ready_out stays 1; done_pulse high for 4 cycles; wr_count=4.
- Assert rst_n low in the middle of S_BUSY → immediately ready_out 0, wr_count 0, mem cleared; after release the S_INIT→S_READY sequence repeats. Also: drive 300 accepts with CNT_W=8 → wr_count holds at 255.
